ram32_arbiter: RTL and testbench
================================

Name: ram32_arbiter

Overview:
Sequences and shares one 32x32 byte-writable RAM macro between two requesters, A and B. The macro's outputs register one cycle after an enabled edge and read before they write. The block performs a hardware zero-fill sweep after reset or on command, then issues at most one access per cycle with round-robin arbitration. Read data returns on a shared bus with a per-requester valid strobe.

Parameters:
INIT_ON_RESET, 1, 1 = run the fill sweep on reset release; 0 = start in SERVE
INIT_VALUE, 32'h0, word written to every address during a fill sweep

Ports:
CLK  input  1  rising-edge clock
RST  input  1  reset, asynchronous, active-high
init_start  input  1  pulse in SERVE starts a fill sweep
init_busy  output  1  high while in INIT
a_valid  input  1  A request valid
a_ready  output  1  A request accepted this cycle
a_we  input  4  A byte write enables; 0 = read
a_addr  input  5  A word address
a_wdata  input  32  A write data
b_valid  input  1  B request valid
b_ready  output  1  B request accepted this cycle
b_we  input  4  B byte write enables
b_addr  input  5  B word address
b_wdata  input  32  B write data
resp_a_valid  output  1  resp_rdata belongs to A
resp_b_valid  output  1  resp_rdata belongs to B
resp_rdata  output  32  response data, shared
ram_en  output  1  to macro EN0
ram_we  output  4  to macro WE0
ram_addr  output  5  to macro A0
ram_di  output  32  to macro Di0
ram_do  input  32  from macro Do0

Behaviour:
- Reset values:
  - state = INIT if INIT_ON_RESET, else SERVE; fill counter = 0; round-robin pointer = A.
  - resp_a_valid = resp_b_valid = 0.
  - With no grant and not in INIT, ram_en/ram_we/ram_addr/ram_di = 0.
  - a_ready = b_ready = 0; init_busy = (state == INIT).
- Reset mid-operation: every register returns to its reset value immediately. Responses in flight are dropped; RAM contents are not guaranteed.
- INIT (32 cycles):
  - Each cycle drives ram_en = 1, ram_we = 4'hF, ram_addr = counter, ram_di = INIT_VALUE.
  - Counter increments each cycle; the cycle with counter == 31 is the last, then state goes to SERVE.
  - Both ready outputs stay low. init_start is ignored while in INIT.
- SERVE arbitration (combinational):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester selected by the pointer.
  - ready_x = 1 only for the granted requester; ready may depend on valid.
  - A handshake is valid && ready, 1 op/cycle, no bubbles.
- Pointer update: after any grant, the pointer moves to the requester not granted. With no grant, the pointer holds.
- Macro drive on grant: ram_en = 1 and ram_we/ram_addr/ram_di come from the winner. Otherwise ram_en = 0 and ram_we = 0.
- Response path:
  - resp_x_valid is registered and equals "x granted in the previous cycle".
  - resp_rdata = ram_do (combinational passthrough).
  - Writes also return a response, carrying the pre-write word (read-before-write). Responses have no backpressure.
- init_start:
  - Sampled in SERVE. Grants in that same cycle still complete; state becomes INIT on the next edge with counter = 0.
  - The response for the last grant appears in the first INIT cycle.
- Data from a fill write is never reported as a response. ram_do is ignored except in the cycle following a grant.

Test Plan:
- Reset release with INIT_ON_RESET=1: init_busy high exactly 32 cycles, ram_addr steps 0..31 with ram_we=F; then an A read of addr 17 -> resp_a_valid one cycle later with resp_rdata=0.
- A writes 32'hDEADBEEF to addr 5 with a_we=4'b0101, then reads addr 5 -> resp_rdata=32'h00AD00EF.
- A and B both valid continuously after reset: grants alternate A,B,A,B; each resp_x_valid lags its grant by 1; no idle cycle.
- Only B valid for 3 cycles, then both valid -> A granted first (pointer pointing to A after B grants).
- init_start pulsed in the same cycle as a B read of addr 3 holding 32'h1234 -> that read completes, resp_b_valid=1 with 32'h1234 in the first INIT cycle, then 32-cycle sweep.
- RST asserted mid-sweep at counter=10 -> outputs return to reset values at once; on release the sweep restarts at address 0.

Source files
------------

// File: rtl/ram32_arbiter.sv
// Round-robin sharing of one 32x32 byte-writable RAM macro between requesters A and B,
// with a hardware fill sweep after reset or on command.
module ram32_arbiter #(
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter logic [31:0] INIT_VALUE    = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        init_start,
    output logic        init_busy,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_we,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_we,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_wdata,
    output logic        resp_a_valid,
    output logic        resp_b_valid,
    output logic [31:0] resp_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_do
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam state_e RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_SERVE;

    state_e      state_r;
    state_e      state_nxt_s;
    logic [4:0]  cnt_r;
    logic [4:0]  cnt_nxt_s;
    logic        ptr_b_r;
    logic        ptr_nxt_s;
    logic        resp_a_r;
    logic        resp_b_r;
    logic        grant_a_s;
    logic        grant_b_s;

    // State, fill counter, round-robin pointer and response strobes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= RESET_STATE;
            cnt_r    <= 5'd0;
            ptr_b_r  <= 1'b0;
            resp_a_r <= 1'b0;
            resp_b_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            ptr_b_r  <= ptr_nxt_s;
            resp_a_r <= grant_a_s;
            resp_b_r <= grant_b_s;
        end
    end

    // Arbitration: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == ST_SERVE) begin
            if (a_valid && (!b_valid || !ptr_b_r)) begin
                grant_a_s = 1'b1;
            end else if (b_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Next state and fill counter; init_start is only honoured while serving
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = 5'd0;
        case (state_r)
            ST_INIT: begin
                cnt_nxt_s = cnt_r + 5'd1;
                if (cnt_r == 5'd31) begin
                    state_nxt_s = ST_SERVE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_SERVE: begin
                cnt_nxt_s = 5'd0;
                if (init_start) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            default: begin
                state_nxt_s = RESET_STATE;
                cnt_nxt_s   = 5'd0;
            end
        endcase
    end

    // Pointer moves to the loser after a grant, holds when idle
    always_comb begin
        ptr_nxt_s = ptr_b_r;
        if (grant_a_s) begin
            ptr_nxt_s = 1'b1;
        end else if (grant_b_s) begin
            ptr_nxt_s = 1'b0;
        end else begin
            ptr_nxt_s = ptr_b_r;
        end
    end

    // Macro drive: fill sweep, then the winner's request, otherwise quiet
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 4'h0;
        ram_addr = 5'd0;
        ram_di   = 32'h0;
        if (state_r == ST_INIT) begin
            ram_en   = 1'b1;
            ram_we   = 4'hF;
            ram_addr = cnt_r;
            ram_di   = INIT_VALUE;
        end else if (grant_a_s) begin
            ram_en   = 1'b1;
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_di   = a_wdata;
        end else if (grant_b_s) begin
            ram_en   = 1'b1;
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_di   = b_wdata;
        end else begin
            ram_en   = 1'b0;
            ram_we   = 4'h0;
            ram_addr = 5'd0;
            ram_di   = 32'h0;
        end
    end

    assign a_ready      = grant_a_s;
    assign b_ready      = grant_b_s;
    assign init_busy    = (state_r == ST_INIT);
    assign resp_a_valid = resp_a_r;
    assign resp_b_valid = resp_b_r;
    // The macro's registered output already lines up with the strobes above
    assign resp_rdata   = ram_do;

endmodule

// File: tb/tb_ram32_arbiter.sv
// Bench for ram32_arbiter: macro model, directed table, random traffic against a
// behavioural reference, fill-sweep, init_start and mid-sweep reset sequences.
module tb_ram32_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        init_start;
    logic        init_busy;
    logic        a_valid, a_ready;
    logic [3:0]  a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_valid, b_ready;
    logic [3:0]  b_we;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata;
    logic        resp_a_valid, resp_b_valid;
    logic [31:0] resp_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_do;

    always #5 CLK = ~CLK;

    ram32_arbiter dut (
        .CLK(CLK), .RST(RST), .init_start(init_start), .init_busy(init_busy),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .resp_a_valid(resp_a_valid), .resp_b_valid(resp_b_valid), .resp_rdata(resp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    // Macro: registered read-before-write output, byte write enables
    logic [31:0] mem [32];
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= mem[ram_addr];
            for (int k = 0; k < 4; k++)
                if (ram_we[k]) mem[ram_addr][8*k +: 8] <= ram_di[8*k +: 8];
        end
    end

    // Reference model: expected contents, sweep progress, who is favoured next
    logic [31:0] ref_mem [32];
    bit          m_init;
    int          m_cnt;
    bit          m_pref_b;
    bit          pend_a, pend_b;
    logic [31:0] pend_data;
    bit          ga, gb;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init   = 1'b1;
        m_cnt    = 0;
        m_pref_b = 1'b0;
        pend_a   = 1'b0;
        pend_b   = 1'b0;
    endtask

    task automatic idle();
        init_start = 1'b0;
        a_valid = 1'b0; a_we = 4'h0; a_addr = 5'd0; a_wdata = 32'h0;
        b_valid = 1'b0; b_we = 4'h0; b_addr = 5'd0; b_wdata = 32'h0;
    endtask

    // Compare every output against the model for the inputs currently applied
    task automatic eval();
        #1;
        ga = !m_init && a_valid && (!b_valid || !m_pref_b);
        gb = !m_init && b_valid && !ga;
        chk("init_busy", 32'(init_busy), 32'(m_init));
        chk("a_ready", 32'(a_ready), 32'(ga));
        chk("b_ready", 32'(b_ready), 32'(gb));
        chk("resp_a_valid", 32'(resp_a_valid), 32'(pend_a));
        chk("resp_b_valid", 32'(resp_b_valid), 32'(pend_b));
        if (pend_a || pend_b) chk("resp_rdata", resp_rdata, pend_data);
        if (m_init) begin
            chk("fill_en", 32'(ram_en), 32'd1);
            chk("fill_we", 32'(ram_we), 32'hF);
            chk("fill_addr", 32'(ram_addr), 32'(m_cnt));
            chk("fill_di", ram_di, 32'h0);
        end else if (ga || gb) begin
            chk("ram_en", 32'(ram_en), 32'd1);
            chk("ram_we", 32'(ram_we), 32'(ga ? a_we : b_we));
            chk("ram_addr", 32'(ram_addr), 32'(ga ? a_addr : b_addr));
            chk("ram_di", ram_di, ga ? a_wdata : b_wdata);
        end else begin
            chk("idle_en", 32'(ram_en), 32'd0);
            chk("idle_we", 32'(ram_we), 32'd0);
        end
    endtask

    // Apply the spec's effect of this cycle to the model and step the clock
    task automatic advance();
        logic [4:0]  ad;
        logic [3:0]  we;
        logic [31:0] wd;
        pend_a = ga;
        pend_b = gb;
        if (ga || gb) begin
            ad = ga ? a_addr : b_addr;
            we = ga ? a_we : b_we;
            wd = ga ? a_wdata : b_wdata;
            pend_data = ref_mem[ad];
            for (int k = 0; k < 4; k++)
                if (we[k]) ref_mem[ad][8*k +: 8] = wd[8*k +: 8];
        end
        if (m_init) begin
            ref_mem[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == 32) m_init = 1'b0;
        end else if (init_start) begin
            m_init = 1'b1;
            m_cnt  = 0;
        end
        if (ga) m_pref_b = 1'b1;
        else if (gb) m_pref_b = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // Run until init_busy drops (bounded) and return how many busy cycles were seen
    task automatic run_sweep(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy) break;
            n++;
            eval();
            advance();
        end
    endtask

    typedef struct {
        logic        av;
        logic [3:0]  awe;
        logic [4:0]  aad;
        logic [31:0] awd;
        logic        bv;
        logic [3:0]  bwe;
        logic [4:0]  bad;
        logic [31:0] bwd;
        logic        xa, xb;
        logic        ra, rb;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [13];
    int   nbusy;

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 5'd17, 32'h0,        1'b0, 4'h0, 5'd0,  32'h0,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 4'h5, 5'd5,  32'hDEADBEEF, 1'b0, 4'h0, 5'd0,  32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 4'h0, 5'd5,  32'h0,        1'b0, 4'h0, 5'd0,  32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b0, 4'h0, 5'd0,  32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h00AD00EF};
        tbl[4]  = '{1'b1, 4'h0, 5'd5,  32'h0,        1'b1, 4'h0, 5'd17, 32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 4'h0, 5'd5,  32'h0,        1'b1, 4'h0, 5'd17, 32'h0,     1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 4'h0, 5'd5,  32'h0,        1'b1, 4'h0, 5'd17, 32'h0,     1'b0, 1'b1, 1'b1, 1'b0, 32'h00AD00EF};
        tbl[7]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 4'h0, 5'd5,  32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 4'h0, 5'd5,  32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 32'h00AD00EF};
        tbl[9]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 4'h0, 5'd5,  32'h0,     1'b0, 1'b1, 1'b0, 1'b1, 32'h00AD00EF};
        tbl[10] = '{1'b1, 4'h0, 5'd5,  32'h0,        1'b1, 4'h0, 5'd5,  32'h0,     1'b1, 1'b0, 1'b0, 1'b1, 32'h00AD00EF};
        tbl[11] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 4'hF, 5'd3,  32'h1234,  1'b0, 1'b1, 1'b1, 1'b0, 32'h00AD00EF};
        tbl[12] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b0, 4'h0, 5'd0,  32'h0,     1'b0, 1'b0, 1'b0, 1'b1, 32'h0};

        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        ram_do = 32'h0;
        idle();
        a_valid = 1'b1;
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #2;
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_resp_a", 32'(resp_a_valid), 32'd0);
        chk("rst_resp_b", 32'(resp_b_valid), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle();

        run_sweep(nbusy);
        chk("sweep_len", 32'(nbusy), 32'd32);

        for (int i = 0; i < 13; i++) begin
            a_valid = tbl[i].av; a_we = tbl[i].awe; a_addr = tbl[i].aad; a_wdata = tbl[i].awd;
            b_valid = tbl[i].bv; b_we = tbl[i].bwe; b_addr = tbl[i].bad; b_wdata = tbl[i].bwd;
            eval();
            chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].xa));
            chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].xb));
            chk($sformatf("vec%0d_resp_a", i), 32'(resp_a_valid), 32'(tbl[i].ra));
            chk($sformatf("vec%0d_resp_b", i), 32'(resp_b_valid), 32'(tbl[i].rb));
            if (tbl[i].ra || tbl[i].rb)
                chk($sformatf("vec%0d_rdata", i), resp_rdata, tbl[i].rd);
            advance();
        end

        // init_start together with a B read of addr 3
        b_valid = 1'b1; b_addr = 5'd3; init_start = 1'b1;
        eval();
        chk("istart_b_ready", 32'(b_ready), 32'd1);
        advance();
        idle();
        #1;
        chk("istart_busy", 32'(init_busy), 32'd1);
        chk("istart_resp_b", 32'(resp_b_valid), 32'd1);
        chk("istart_rdata", resp_rdata, 32'h1234);
        chk("istart_addr0", 32'(ram_addr), 32'd0);
        run_sweep(nbusy);
        chk("istart_sweep_len", 32'(nbusy), 32'd32);

        for (int i = 0; i < 400; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            a_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            a_addr  = 5'($urandom);
            a_wdata = $urandom;
            b_valid = 1'($urandom_range(0, 1));
            b_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            b_addr  = 5'($urandom);
            b_wdata = $urandom;
            init_start = ($urandom_range(0, 63) == 0);
            eval();
            advance();
        end
        idle();

        // Reset in the middle of a sweep
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            eval();
            advance();
        end
        #1;
        chk("mid_addr10", 32'(ram_addr), 32'd10);
        a_valid = 1'b1;
        RST = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_busy", 32'(init_busy), 32'd1);
        chk("mid_rst_we", 32'(ram_we), 32'hF);
        chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_resp", 32'({resp_a_valid, resp_b_valid}), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle();
        run_sweep(nbusy);
        chk("mid_sweep_len", 32'(nbusy), 32'd32);

        a_valid = 1'b1; a_addr = 5'd17;
        eval();
        advance();
        idle();
        eval();
        chk("post_read17", resp_rdata, 32'h0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
